// File: rtl/param_seq_detector.sv
// ---------------------------------------------------------------------------
// param_seq_detector
//
// Runtime-programmable serial bit-pattern detector. Each bit accepted on x
// (qualified by x_valid) shifts into a history register. The newest pat_len
// bits are compared against pattern[pat_len-1:0]. pattern[pat_len-1] is the
// first bit of the sequence and pattern[0] is the last. A hit gives a
// registered one-cycle pulse on z. It also bumps a saturating match counter.
//
// Optional feature, macro SEQDET_MASK_EN:
//   When defined, the input pat_mask is added. Bits with pat_mask = 0 are
//   don't-care in the compare. When undefined, all pat_len bits are compared.
//
// Parameters:
//   MAX_LEN  maximum pattern length, 2..32
//   LEN_W    width of pat_len (2**LEN_W > MAX_LEN)
//   CNT_W    width of match_count
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   x            serial data bit
//   x_valid      x is accepted on a rising edge only when high
//   pattern      pattern bits, MSB of the active window received first
//   pat_mask     (SEQDET_MASK_EN only) per-bit compare enable
//   pat_len      active pattern length
//   overlap      1 = overlapping matches, 0 = restart after each match
//   clear        synchronous clear of history, fill, counter and z
//   z            registered one-cycle match pulse
//   match_count  saturating match counter
//   cfg_err      registered flag, set while pat_len is outside 2..MAX_LEN
// ---------------------------------------------------------------------------
module param_seq_detector #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               x_valid,
  input  logic [MAX_LEN-1:0] pattern,
`ifdef SEQDET_MASK_EN
  input  logic [MAX_LEN-1:0] pat_mask,
`endif
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               clear,
  output logic               z,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] MIN_LEN_L = LEN_W'(2);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [MAX_LEN-1:0] hist_reg;
  logic [LEN_W-1:0]   fill_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               z_reg;
  logic               cfg_err_reg;

  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_inc;
  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] cmp_mask;
  logic [MAX_LEN-1:0] miss_bits;
  logic               cfg_ok;
  logic               accept;
  logic               match_next;

  // A bit that arrives together with clear is dropped, because clear wins.
  assign accept = x_valid && !clear;

  assign cfg_ok = (pat_len >= MIN_LEN_L) && (pat_len <= MAX_LEN_L);

  assign hist_next = {hist_reg[MAX_LEN-2:0], x};

  // fill only needs to reach MAX_LEN. Any legal pat_len is already covered
  // at that point, so the counter stops there.
  assign fill_inc = (fill_reg == MAX_LEN_L) ? fill_reg : fill_reg + LEN_W'(1);

  // Compare window: the lowest pat_len bits of the post-shift history.
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_len_mask
      localparam logic [LEN_W-1:0] GI_L = LEN_W'(gi);
      assign len_mask[gi] = (GI_L < pat_len);
    end
  endgenerate

`ifdef SEQDET_MASK_EN
  assign cmp_mask = len_mask & pat_mask;
`else
  assign cmp_mask = len_mask;
`endif

  assign miss_bits = (hist_next ^ pattern) & cmp_mask;

  assign match_next = accept && cfg_ok && (fill_inc >= pat_len) &&
                      (miss_bits == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_reg    <= '0;
      fill_reg    <= '0;
      count_reg   <= '0;
      z_reg       <= 1'b0;
      cfg_err_reg <= 1'b0;
    end else begin
      cfg_err_reg <= !cfg_ok;
      if (clear) begin
        hist_reg  <= '0;
        fill_reg  <= '0;
        count_reg <= '0;
        z_reg     <= 1'b0;
      end else begin
        z_reg <= match_next;
        if (accept) begin
          hist_reg <= hist_next;
          // In non-overlap mode, a match restarts the fill count. The next
          // match then needs pat_len fresh bits. The history still shifts.
          fill_reg <= (match_next && !overlap) ? '0 : fill_inc;
        end
        if (match_next && (count_reg != CNT_MAX)) begin
          count_reg <= count_reg + CNT_W'(1);
        end
      end
    end
  end

  assign z           = z_reg;
  assign match_count = count_reg;
  assign cfg_err     = cfg_err_reg;

endmodule

// File: tb/tb_param_seq_detector.sv
// ---------------------------------------------------------------------------
// tb_param_seq_detector
//
// Directed testbench for param_seq_detector. It builds two instances that
// share the same stimulus:
//   dut      default parameters
//   dut_sat  CNT_W = 2, used to observe counter saturation
// Each accepted bit or event prints one line.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_param_seq_detector;

  logic       clk;
  logic       reset;
  logic       x;
  logic       x_valid;
  logic [7:0] pattern;
  logic [7:0] pat_mask;
  logic [3:0] pat_len;
  logic       overlap;
  logic       clear;

  logic        z;
  logic [15:0] match_count;
  logic        cfg_err;
  logic        z_s;
  logic [1:0]  cnt_s;
  logic        cfg_err_s;

  int n_checks;
  int n_fails;

  param_seq_detector #(.MAX_LEN(8), .LEN_W(4), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .x_valid     (x_valid),
    .pattern     (pattern),
`ifdef SEQDET_MASK_EN
    .pat_mask    (pat_mask),
`endif
    .pat_len     (pat_len),
    .overlap     (overlap),
    .clear       (clear),
    .z           (z),
    .match_count (match_count),
    .cfg_err     (cfg_err)
  );

  param_seq_detector #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut_sat (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .x_valid     (x_valid),
    .pattern     (pattern),
`ifdef SEQDET_MASK_EN
    .pat_mask    (pat_mask),
`endif
    .pat_len     (pat_len),
    .overlap     (overlap),
    .clear       (clear),
    .z           (z_s),
    .match_count (cnt_s),
    .cfg_err     (cfg_err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one bit between edges and let the next rising edge take it.
  // z is then sampled 1 ns after that edge.
  task automatic send_bit(input logic b, input logic v, input logic exp_z,
                          input string tag);
    @(negedge clk);
    x       = b;
    x_valid = v;
    @(posedge clk);
    #1;
    $display("%s: x=%0b v=%0b z=%0b cnt=%0d cnt_s=%0d cfg_err=%0b",
             tag, b, v, z, match_count, cnt_s, cfg_err);
    check_eq(tag, 32'(z), 32'(exp_z));
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear   = 1'b1;
    x_valid = 1'b0;
    @(posedge clk);
    #1;
    clear = 1'b0;
    $display("clear: z=%0b cnt=%0d", z, match_count);
    check_eq("clear_cnt", 32'(match_count), 32'd0);
  endtask

  // Bounded run time: a stuck bench still reports and stops.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] s1;
    logic [6:0] e1;
    logic [9:0] s2;
    logic [9:0] e2;
    logic [1:0] sat_exp [6];

    n_checks = 0;
    n_fails  = 0;
    reset    = 1'b0;
    x        = 1'b0;
    x_valid  = 1'b0;
    pattern  = 8'b0000_1011;
    pat_mask = 8'hFF;
    pat_len  = 4'd4;
    overlap  = 1'b1;
    clear    = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_z", 32'(z), 32'd0);
    check_eq("rst_cnt", 32'(match_count), 32'd0);
    check_eq("rst_cfg_err", 32'(cfg_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Overlap: 1011011 gives pulses after bits 4 and 7
    s1 = 7'b1011011;
    e1 = 7'b0001001;
    for (int i = 0; i < 7; i++)
      send_bit(s1[6-i], 1'b1, e1[6-i], $sformatf("ovl_bit%0d", i + 1));
    check_eq("ovl_cnt", 32'(match_count), 32'd2);

    // Non-overlap: 1011011011 gives pulses after bits 4 and 10 only
    do_clear();
    overlap = 1'b0;
    s2 = 10'b1011011011;
    e2 = 10'b0001000001;
    for (int i = 0; i < 10; i++)
      send_bit(s2[9-i], 1'b1, e2[9-i], $sformatf("novl_bit%0d", i + 1));
    check_eq("novl_cnt", 32'(match_count), 32'd2);

    // Valid gaps: 1,0,<3 invalid cycles with x=1>,1,1
    do_clear();
    overlap = 1'b1;
    send_bit(1'b1, 1'b1, 1'b0, "gap_bit1");
    send_bit(1'b0, 1'b1, 1'b0, "gap_bit2");
    for (int i = 0; i < 3; i++)
      send_bit(1'b1, 1'b0, 1'b0, $sformatf("gap_idle%0d", i + 1));
    send_bit(1'b1, 1'b1, 1'b0, "gap_bit3");
    send_bit(1'b1, 1'b1, 1'b1, "gap_bit4");
    check_eq("gap_cnt", 32'(match_count), 32'd1);

    // Saturation on the CNT_W=2 instance: pattern 11, six ones
    do_clear();
    pattern = 8'b0000_0011;
    pat_len = 4'd2;
    sat_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 6; i++) begin
      send_bit(1'b1, 1'b1, (i != 0), $sformatf("sat_bit%0d", i + 1));
      check_eq($sformatf("sat_cnt%0d", i + 1), 32'(cnt_s), 32'(sat_exp[i]));
    end
    check_eq("sat_wide_cnt", 32'(match_count), 32'd5);

    // clear together with an accepted bit: the bit is discarded
    @(negedge clk);
    clear   = 1'b1;
    x       = 1'b1;
    x_valid = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    $display("clear_with_bit: z=%0b cnt_s=%0d", z, cnt_s);
    check_eq("clrbit_cnt_s", 32'(cnt_s), 32'd0);
    check_eq("clrbit_z", 32'(z), 32'd0);
    // Only one bit of history now, so no match yet
    send_bit(1'b1, 1'b1, 1'b0, "clrbit_next");

    // Illegal length 0: cfg_err is registered, so it is still low right away
    pat_len = 4'd0;
    #1;
    check_eq("cfg0_latency", 32'(cfg_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b1, 1'b1, 1'b0, $sformatf("len0_bit%0d", i + 1));
      check_eq($sformatf("len0_err%0d", i + 1), 32'(cfg_err), 32'd1);
    end
    check_eq("len0_cnt", 32'(match_count), 32'd0);

    // Illegal length MAX_LEN+1
    pattern = 8'hFF;
    pat_len = 4'd9;
    for (int i = 0; i < 9; i++)
      send_bit(1'b1, 1'b1, 1'b0, $sformatf("len9_bit%0d", i + 1));
    check_eq("len9_err", 32'(cfg_err), 32'd1);
    check_eq("len9_cnt", 32'(match_count), 32'd0);

    // A legal config applies on the very next compare (history kept)
    pattern = 8'b0000_0011;
    pat_len = 4'd2;
    send_bit(1'b1, 1'b1, 1'b1, "relegal_bit");
    check_eq("relegal_err", 32'(cfg_err), 32'd0);
    check_eq("relegal_cnt", 32'(match_count), 32'd1);

    // Reset mid-stream after 3 of 4 bits of 1011
    pattern = 8'b0000_1011;
    pat_len = 4'd4;
    send_bit(1'b1, 1'b1, 1'b0, "mrst_bit1");
    send_bit(1'b0, 1'b1, 1'b0, "mrst_bit2");
    send_bit(1'b1, 1'b1, 1'b0, "mrst_bit3");
    @(negedge clk);
    x_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    $display("mid_reset: z=%0b cnt=%0d cfg_err=%0b", z, match_count, cfg_err);
    check_eq("mrst_cnt", 32'(match_count), 32'd0);
    check_eq("mrst_z", 32'(z), 32'd0);
    check_eq("mrst_cfg_err", 32'(cfg_err), 32'd0);
    reset = 1'b1;
    send_bit(1'b1, 1'b1, 1'b0, "mrst_bit4");
    check_eq("mrst_cnt_after", 32'(match_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
